// File: rtl/ext_pipe.sv
// Buffered immediate-extension unit: extends an IN_W immediate per mode and queues
// results in a DEPTH-entry FIFO. Optional illegal-mode trap under EXT_ILLEGAL_TRAP_EN.
module ext_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int DEPTH    = 2,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
`ifdef EXT_ILLEGAL_TRAP_EN
    output logic             illegal,
`endif
    output logic [CW-1:0]    count
);

    logic [OUT_W-1:0] sx, zx, br, up, ext;
    logic             ext_ill;
    logic             push, pop;

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        sx = {OUT_W{imm[IN_W-1]}};
        sx[IN_W-1:0] = imm;
        zx = '0;
        zx[IN_W-1:0] = imm;
        br = sx << BR_SHIFT;
        up = '0;
        up[OUT_W-1 -: IN_W] = imm;
        ext_ill = 1'b0;
        case (mode)
            3'd0:    ext = sx;
            3'd1:    ext = zx;
            3'd2:    ext = br;
            3'd3:    ext = up;
            default: begin
`ifdef EXT_ILLEGAL_TRAP_EN
                ext     = '0;
                ext_ill = 1'b1;
`else
                ext     = zx;
`endif
            end
        endcase
    end

    // Handshake readiness depends only on registered occupancy.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    assign result    = out_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left uninitialised; result is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= ext;
    end

`ifdef EXT_ILLEGAL_TRAP_EN
    logic [DEPTH-1:0] stat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_q <= '0;
        end else if (flush) begin
            stat_q <= '0;
        end else if (push) begin
            stat_q[wr_ptr_q] <= ext_ill;
        end
    end

    assign illegal = out_valid && stat_q[rd_ptr_q];
`else
    logic unused_ill;
    assign unused_ill = ext_ill;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe at default parameters (DEPTH=2).
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] imm = '0;
    logic [2:0]  mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [1:0]  count;
`ifdef EXT_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int vectors = 0;
    int miscompares = 0;

    ext_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef EXT_ILLEGAL_TRAP_EN
        .illegal   (illegal),
`endif
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] c, input logic ov,
                             input logic ir, input logic [31:0] r);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
        chk({tag, ".result"}, result, r);
    endtask

    initial begin
        #2;
        chk_state("reset", 2'd0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // single sign-extend push
        in_valid = 1'b1; imm = 16'h8001; mode = 3'd0;
        @(negedge clk);
        chk_state("sign", 2'd1, 1'b1, 1'b1, 32'hFFFF8001);

        // back-to-back modes 1..3 with streaming consumer
        out_ready = 1'b1; mode = 3'd1;
        @(negedge clk);
        chk_state("zero", 2'd1, 1'b1, 1'b1, 32'h00008001);
        mode = 3'd2;
        @(negedge clk);
        chk_state("branch", 2'd1, 1'b1, 1'b1, 32'hFFFE0004);
        mode = 3'd3;
        @(negedge clk);
        chk_state("upper", 2'd1, 1'b1, 1'b1, 32'h80010000);
        in_valid = 1'b0;
        @(negedge clk);
        chk_state("drain", 2'd0, 1'b0, 1'b1, 32'h0);

        // fill with consumer stalled
        out_ready = 1'b0; in_valid = 1'b1; mode = 3'd1; imm = 16'h0001;
        @(negedge clk);
        chk_state("fill1", 2'd1, 1'b1, 1'b1, 32'h1);
        imm = 16'h0002;
        @(negedge clk);
        chk_state("fill2", 2'd2, 1'b1, 1'b0, 32'h1);
        imm = 16'h0003;
        @(negedge clk);
        chk_state("full_hold", 2'd2, 1'b1, 1'b0, 32'h1);
        chk("full_held_result", result, 32'h1);

        // release consumer: full cycle only pops, then push/pop overlap across wrap
        out_ready = 1'b1;
        @(negedge clk);
        chk_state("release", 2'd1, 1'b1, 1'b1, 32'h2);
        @(negedge clk);
        chk_state("overlap1", 2'd1, 1'b1, 1'b1, 32'h3);
        imm = 16'h0004;
        @(negedge clk);
        chk_state("overlap_wrap", 2'd1, 1'b1, 1'b1, 32'h4);
        out_ready = 1'b0; imm = 16'h0005;
        @(negedge clk);
        chk_state("refill", 2'd2, 1'b1, 1'b0, 32'h4);

        // flush while full with push and pop requested
        flush = 1'b1; out_ready = 1'b1; imm = 16'h0006;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk_state("flush", 2'd0, 1'b0, 1'b1, 32'h0);

        // async reset between edges with one entry queued
        in_valid = 1'b1; imm = 16'h00AA;
        @(negedge clk);
        in_valid = 1'b0;
        chk_state("pre_areset", 2'd1, 1'b1, 1'b1, 32'h000000AA);
        #2 reset = 1'b0;
        #1;
        chk_state("areset", 2'd0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_state("post_reset", 2'd0, 1'b0, 1'b1, 32'h0);

        // illegal mode
        in_valid = 1'b1; mode = 3'd5; imm = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef EXT_ILLEGAL_TRAP_EN
        chk_state("illegal", 2'd1, 1'b1, 1'b1, 32'h0);
        chk("illegal.flag", 32'(illegal), 32'h1);
`else
        chk_state("illegal", 2'd1, 1'b1, 1'b1, 32'h00001234);
`endif

        // negative branch offset truncation and upper mode with a second value
        out_ready = 1'b1; in_valid = 1'b1; mode = 3'd2; imm = 16'hFFFF;
        @(negedge clk);
        chk_state("branch_neg", 2'd1, 1'b1, 1'b1, 32'hFFFFFFFC);
        mode = 3'd3; imm = 16'h7FFE;
        @(negedge clk);
        in_valid = 1'b0;
        chk_state("upper2", 2'd1, 1'b1, 1'b1, 32'h7FFE0000);
        @(negedge clk);
        chk_state("end_drain", 2'd0, 1'b0, 1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
